// File: rtl/buffer_b_sched_if.sv
// Request channel from the host sequencer into the B-buffer command scheduler.
interface buffer_b_sched_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_buf;
  logic [7:0] req_dim_x;
  logic [7:0] req_dim_y;

  modport master (output req_valid, req_op, req_buf, req_dim_x, req_dim_y, input req_ready);
  modport slave  (input req_valid, req_op, req_buf, req_dim_x, req_dim_y, output req_ready);
endinterface

// File: rtl/buffer_b_sched.sv
// Queued LOAD/SEND/CLEAR scheduler for the B-operand buffer bank with shadow occupancy tracking.
// Optional request validation is enabled by defining BUF_B_SCHED_CHECK_EN.
module buffer_b_sched #(
  parameter int unsigned MMU_SIZE   = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  buffer_b_sched_if.slave     req,
  input  logic                stop_in,
  output logic [1:0]          buf_cmd,
  output logic [4:0]          buf_sel,
  output logic [7:0]          buf_dim_x,
  output logic [7:0]          buf_dim_y,
  output logic                buf_stop,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [MMU_SIZE-1:0] loaded
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SLOTS = 16;
  localparam logic [1:0] OP_NOP = 2'b00, OP_LOAD = 2'b01, OP_SEND = 2'b10, OP_CLEAR = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] buf_id;
    logic [7:0] dim_x;
    logic [7:0] dim_y;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DRAIN} state_t;

  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_next;
  logic             push, pop, head_ok, head_reject, cur_in_range;
  req_t             head, cur;
  state_t           state, state_next;
  logic [15:0]      run_cnt, run_cnt_next, run_len;
  logic [7:0]       shadow_x [SLOTS];
  logic [7:0]       shadow_y [SLOTS];
  logic [SLOTS-1:0] loaded_upd;

  assign head          = fifo_mem[rd_ptr];
  assign push          = req.req_valid && req.req_ready;
  assign pop           = (state == S_IDLE) && (fifo_cnt != '0);
  assign fifo_cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  assign cur_in_range  = 32'(cur.buf_id) < MMU_SIZE;
  assign head_ok       = (head.op != OP_NOP) && !head_reject;
  // Stall is ignored by the buffer while it clears, so it is masked here too.
  assign buf_stop      = stop_in && !((state != S_IDLE) && (cur.op == OP_CLEAR));

`ifdef BUF_B_SCHED_CHECK_EN
  logic [SLOTS-1:0] loaded_ext;
  assign loaded_ext = SLOTS'(loaded);

  always_comb begin
    head_reject = 1'b0;
    if (head.op != OP_NOP) begin
      if (32'(head.buf_id) >= MMU_SIZE)
        head_reject = 1'b1;
      else if ((head.op == OP_SEND) && !loaded_ext[head.buf_id])
        head_reject = 1'b1;
      else if ((head.op == OP_LOAD) && ((32'(head.dim_x) > MMU_SIZE) || (32'(head.dim_y) > MMU_SIZE)))
        head_reject = 1'b1;
    end
  end
`else
  assign head_reject = 1'b0;
`endif

  // Run length of the operation latched at issue.
  always_comb begin
    case (cur.op)
      OP_LOAD:  run_len = 16'(cur.dim_x) * 16'(cur.dim_y);
      OP_SEND:  run_len = 16'(shadow_x[cur.buf_id]);
      OP_CLEAR: run_len = 16'(MMU_SIZE);
      default:  run_len = '0;
    endcase
  end

  // Out-of-range slots fall into the padding bits and are dropped on write-back.
  always_comb begin
    loaded_upd              = SLOTS'(loaded);
    loaded_upd[cur.buf_id]  = (cur.op == OP_LOAD);
  end

  always_comb begin
    state_next   = state;
    run_cnt_next = run_cnt;
    case (state)
      S_IDLE:  if (pop && head_ok) state_next = S_ISSUE;
      S_ISSUE: begin
        run_cnt_next = run_len;
        state_next   = (run_len == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: if (!(stop_in && (cur.op != OP_CLEAR))) begin
        run_cnt_next = run_cnt - 16'd1;
        if (run_cnt == 16'd1) state_next = S_DRAIN;
      end
      S_DRAIN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{req.req_op, req.req_buf, req.req_dim_x, req.req_dim_y};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      run_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      cur           <= '0;
      req.req_ready <= 1'b1;
      busy          <= 1'b0;
      buf_cmd       <= '0;
      buf_sel       <= '0;
      buf_dim_x     <= '0;
      buf_dim_y     <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      loaded        <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
      end
    end else begin
      state         <= state_next;
      run_cnt       <= run_cnt_next;
      fifo_cnt      <= fifo_cnt_next;
      req.req_ready <= (fifo_cnt_next != CNT_W'(FIFO_DEPTH));
      busy          <= (state_next != S_IDLE) || (fifo_cnt_next != '0);
      buf_cmd       <= '0;
      done          <= 1'b0;
      err           <= pop && head_reject;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop && head_ok) begin
        cur     <= head;
        buf_cmd <= head.op;
        buf_sel <= 5'(head.buf_id);
        // SEND carries the stored geometry; LOAD and CLEAR carry the request's.
        buf_dim_x <= (head.op == OP_SEND) ? shadow_x[head.buf_id] : head.dim_x;
        buf_dim_y <= (head.op == OP_SEND) ? shadow_y[head.buf_id] : head.dim_y;
      end
      if (state_next == S_DRAIN) begin
        done <= 1'b1;
        if ((cur.op == OP_LOAD) || (cur.op == OP_CLEAR)) begin
          loaded <= loaded_upd[MMU_SIZE-1:0];
          if (cur_in_range) begin
            shadow_x[cur.buf_id] <= (cur.op == OP_LOAD) ? cur.dim_x : 8'd0;
            shadow_y[cur.buf_id] <= (cur.op == OP_LOAD) ? cur.dim_y : 8'd0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_buffer_b_sched.sv
// Directed bench for buffer_b_sched: load/send/clear timing, queue full, validation, mid-run reset.
module tb_buffer_b_sched;
  localparam int unsigned MMU_SIZE = 10;
`ifdef BUF_B_SCHED_CHECK_EN
  localparam int EXP_ERR = 2;
  localparam int EXP_CMD = 0;
`else
  localparam int EXP_ERR = 0;
  localparam int EXP_CMD = 2;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                stop_in = 1'b0;
  logic [1:0]          buf_cmd;
  logic [4:0]          buf_sel;
  logic [7:0]          buf_dim_x, buf_dim_y;
  logic                buf_stop, busy, done, err;
  logic [MMU_SIZE-1:0] loaded;
  int                  total = 0;
  int                  bad = 0;

  buffer_b_sched_if rif();

  buffer_b_sched #(.MMU_SIZE(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(rif), .stop_in(stop_in),
    .buf_cmd(buf_cmd), .buf_sel(buf_sel), .buf_dim_x(buf_dim_x), .buf_dim_y(buf_dim_y),
    .buf_stop(buf_stop), .busy(busy), .done(done), .err(err), .loaded(loaded)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [1:0] op, input logic [3:0] b, input logic [7:0] dx, input logic [7:0] dy);
    rif.req_valid = 1'b1; rif.req_op = op; rif.req_buf = b; rif.req_dim_x = dx; rif.req_dim_y = dy;
    tick();
    rif.req_valid = 1'b0;
  endtask

  task automatic wait_cmd(input int maxc, output int n);
    n = 0;
    while (buf_cmd == 2'b00) begin
      if (n >= maxc) begin n = -1; return; end
      tick(); n++;
    end
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (done !== 1'b1) begin
      if (n >= maxc) begin n = -1; return; end
      tick(); n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    total++; if (buf_cmd !== 2'b00) begin bad++; $display("FAIL rst_cmd got=%0h exp=0", buf_cmd); end
    total++; if (buf_sel !== 5'd0 || buf_dim_x !== 8'd0 || buf_dim_y !== 8'd0) begin bad++; $display("FAIL rst_sel_dims got=%0h/%0h/%0h exp=0", buf_sel, buf_dim_x, buf_dim_y); end
    total++; if (rif.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", rif.req_ready); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || buf_stop !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b%0b%0b%0b exp=0000", busy, done, err, buf_stop); end
    total++; if (loaded !== 10'd0) begin bad++; $display("FAIL rst_loaded got=%b exp=0", loaded); end
  endtask

  task automatic test_load();
    int n;
    push_req(2'b01, 4'd3, 8'd4, 8'd5);
    total++; if (buf_cmd !== 2'b00) begin bad++; $display("FAIL load_cmd_early got=%0h exp=0", buf_cmd); end
    tick();
    total++; if (buf_cmd !== 2'b01 || buf_sel !== 5'd3) begin bad++; $display("FAIL load_issue got=%0h/%0d exp=1/3", buf_cmd, buf_sel); end
    total++; if (buf_dim_x !== 8'd4 || buf_dim_y !== 8'd5) begin bad++; $display("FAIL load_dims got=%0d/%0d exp=4/5", buf_dim_x, buf_dim_y); end
    wait_done(100, n);
    total++; if (n != 21) begin bad++; $display("FAIL load_done_lat got=%0d exp=21", n); end
    tick();
    total++; if (loaded !== 10'b0000001000) begin bad++; $display("FAIL load_loaded got=%b exp=0000001000", loaded); end
    total++; if (done !== 1'b0 || busy !== 1'b0 || buf_sel !== 5'd3) begin bad++; $display("FAIL load_after got=%0b/%0b/%0d exp=0/0/3", done, busy, buf_sel); end
  endtask

  task automatic test_send_stall();
    int n;
    logic mirror_ok;
    mirror_ok = 1'b1;
    push_req(2'b10, 4'd3, 8'd0, 8'd0);
    tick();
    total++; if (buf_cmd !== 2'b10 || buf_sel !== 5'd3) begin bad++; $display("FAIL send_issue got=%0h/%0d exp=2/3", buf_cmd, buf_sel); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick(); n++;
      if (done === 1'b1) break;
      stop_in = (n >= 2 && n <= 4);
      #1;
      if (buf_stop !== stop_in) mirror_ok = 1'b0;
    end
    stop_in = 1'b0;
    total++; if (n != 8) begin bad++; $display("FAIL send_done_lat got=%0d exp=8", n); end
    total++; if (mirror_ok !== 1'b1) begin bad++; $display("FAIL send_stop_mirror got=%0b exp=1", mirror_ok); end
    tick();
    total++; if (loaded !== 10'b0000001000) begin bad++; $display("FAIL send_loaded got=%b exp=0000001000", loaded); end
  endtask

  task automatic test_clear();
    int n;
    logic stop_seen;
    stop_seen = 1'b0;
    stop_in = 1'b1;
    push_req(2'b11, 4'd3, 8'd0, 8'd0);
    tick();
    total++; if (buf_cmd !== 2'b11) begin bad++; $display("FAIL clear_issue got=%0h exp=3", buf_cmd); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick(); n++;
      if (buf_stop !== 1'b0) stop_seen = 1'b1;
    end
    total++; if (n != 11) begin bad++; $display("FAIL clear_done_lat got=%0d exp=11", n); end
    total++; if (stop_seen !== 1'b0) begin bad++; $display("FAIL clear_buf_stop got=%0b exp=0", stop_seen); end
    stop_in = 1'b0;
    tick();
    total++; if (loaded !== 10'd0) begin bad++; $display("FAIL clear_loaded got=%b exp=0", loaded); end
  endtask

  task automatic test_back_to_back();
    int n;
    int cmds;
    logic [1:0] ops [4];
    logic [3:0] bufs [4];
    ops[0] = 2'b11; bufs[0] = 4'd0;
    ops[1] = 2'b01; bufs[1] = 4'd5;
    ops[2] = 2'b11; bufs[2] = 4'd1;
    ops[3] = 2'b01; bufs[3] = 4'd6;
    push_req(2'b01, 4'd2, 8'd10, 8'd10);
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) push_req(ops[k], bufs[k], (k == 1) ? 8'd1 : 8'd2, (k == 1) ? 8'd2 : 8'd1);
      else       push_req(2'b01, 4'd8, 8'd1, 8'd1);
      total++; if (rif.req_ready !== (k < 3)) begin bad++; $display("FAIL full_ready_%0d got=%0b exp=%0b", k, rif.req_ready, (k < 3)); end
    end
    for (int k = 0; k < 4; k++) begin
      wait_cmd(150, n);
      total++; if (n < 0 || buf_cmd !== ops[k] || buf_sel !== 5'(bufs[k])) begin bad++; $display("FAIL order_%0d got=%0h/%0d exp=%0h/%0d", k, buf_cmd, buf_sel, ops[k], bufs[k]); end
      tick();
    end
    wait_done(20, n);
    cmds = 0;
    repeat (10) begin tick(); if (buf_cmd != 2'b00) cmds++; end
    total++; if (cmds != 0 || busy !== 1'b0) begin bad++; $display("FAIL full_extra got=%0d/%0b exp=0/0", cmds, busy); end
    total++; if (loaded !== 10'b0001100100) begin bad++; $display("FAIL full_loaded got=%b exp=0001100100", loaded); end
  endtask

  task automatic test_check();
    int errs;
    int cmds;
    errs = 0; cmds = 0;
    push_req(2'b10, 4'd7, 8'd0, 8'd0);
    errs += int'(err); cmds += int'(buf_cmd != 2'b00);
    push_req(2'b01, 4'd12, 8'd1, 8'd1);
    errs += int'(err); cmds += int'(buf_cmd != 2'b00);
    repeat (12) begin tick(); errs += int'(err); cmds += int'(buf_cmd != 2'b00); end
    total++; if (errs != EXP_ERR) begin bad++; $display("FAIL check_err got=%0d exp=%0d", errs, EXP_ERR); end
    total++; if (cmds != EXP_CMD) begin bad++; $display("FAIL check_cmd got=%0d exp=%0d", cmds, EXP_CMD); end
    total++; if (loaded !== 10'b0001100100 || busy !== 1'b0) begin bad++; $display("FAIL check_state got=%b/%0b exp=0001100100/0", loaded, busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    int cmds;
    push_req(2'b01, 4'd4, 8'd10, 8'd10);
    wait_cmd(5, n);
    total++; if (n != 1) begin bad++; $display("FAIL mid_issue_lat got=%0d exp=1", n); end
    repeat (5) tick();
    push_req(2'b11, 4'd0, 8'd0, 8'd0);
    rst_n = 1'b0;
    tick();
    total++; if (buf_cmd !== 2'b00 || buf_sel !== 5'd0 || buf_dim_x !== 8'd0 || buf_dim_y !== 8'd0) begin bad++; $display("FAIL mid_rst_bus got=%0h/%0d/%0d/%0d exp=0", buf_cmd, buf_sel, buf_dim_x, buf_dim_y); end
    total++; if (loaded !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || rif.req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_flags got=%b/%0b/%0b/%0b exp=0/0/0/1", loaded, busy, done, rif.req_ready); end
    rst_n = 1'b1;
    cmds = 0;
    repeat (6) begin tick(); if (buf_cmd != 2'b00 || done !== 1'b0) cmds++; end
    total++; if (cmds != 0) begin bad++; $display("FAIL mid_flush got=%0d exp=0", cmds); end
    push_req(2'b01, 4'd2, 8'd1, 8'd3);
    tick();
    total++; if (buf_cmd !== 2'b01 || buf_sel !== 5'd2) begin bad++; $display("FAIL mid_reissue got=%0h/%0d exp=1/2", buf_cmd, buf_sel); end
    wait_done(20, n);
    total++; if (n != 4) begin bad++; $display("FAIL mid_done_lat got=%0d exp=4", n); end
    tick();
    total++; if (loaded !== 10'b0000000100) begin bad++; $display("FAIL mid_loaded got=%b exp=0000000100", loaded); end
  endtask

  initial begin
    rif.req_valid = 1'b0; rif.req_op = 2'b00; rif.req_buf = 4'd0; rif.req_dim_x = 8'd0; rif.req_dim_y = 8'd0;
    test_reset();
    test_load();
    test_send_stall();
    test_clear();
    test_back_to_back();
    test_check();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
